// File: rtl/dsp_io_pkg.sv
// Shared types and conversion helpers for the DSP IO register bank.
// Holds the default bank geometry, the read-path sign alignment and the
// write-path saturating narrowing. The helpers are sized by the widths below;
// dsp_io_bank refuses to elaborate with a geometry that differs from them.
package dsp_io_pkg;

    localparam int unsigned DATA_WIDTH = 36;
    localparam int unsigned IO_WIDTH   = 24;
    localparam int unsigned NUM_IO     = 8;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned GUARD_BITS = 4;

    // Zero bits below the IO word on the core side; signed so a bad geometry shows as negative.
    localparam int LSB_PAD = int'(DATA_WIDTH) - int'(IO_WIDTH) - int'(GUARD_BITS);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [IO_WIDTH-1:0]   io_t;

    // Narrowed write sample plus the flag saying it had to be clamped.
    typedef struct packed {
        logic clipped;
        io_t  value;
    } sat_t;

    // Place an IO word under GUARD_BITS of sign extension with LSB_PAD zeros below it.
    function automatic data_t sign_align(input io_t x);
        data_t ext;
        ext = DATA_WIDTH'(signed'(x));
        return ext << LSB_PAD;
    endfunction

    // Guard bits plus the IO sign bit must agree, otherwise clamp toward the sign of w.
    function automatic sat_t sat_narrow(input data_t w);
        logic [GUARD_BITS:0] head;
        sat_t                r;
        head      = w[DATA_WIDTH-1 -: GUARD_BITS+1];
        r.clipped = !((head == '0) || (head == '1));
        if (r.clipped) begin
            r.value = w[DATA_WIDTH-1] ? {1'b1, {(IO_WIDTH-1){1'b0}}}
                                      : {1'b0, {(IO_WIDTH-1){1'b1}}};
        end else begin
            r.value = w[DATA_WIDTH-GUARD_BITS-1 -: IO_WIDTH];
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_io_sat.sv
// Combinational saturating narrower for the core-to-IO write path.
// Ports:
//   w          core-side sample word
//   value_c    narrowed IO word (truncated, or clamped to max positive/negative)
//   clipped_c  high when the word had to be clamped
module dsp_io_sat
    import dsp_io_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] w,
    output logic [IO_WIDTH-1:0]   value_c,
    output logic                  clipped_c
);

    sat_t res_c;

    always_comb begin
        res_c     = sat_narrow(w);
        value_c   = res_c.value;
        clipped_c = res_c.clipped;
    end

endmodule

// File: rtl/dsp_io_bank.sv
// Frame-synchronous IO register bank between a DSP core IO bus and its audio channels.
// Inputs are snapshotted into in_shadow and staged outputs are committed to out_data on
// the same frame_tick edge, so the core only ever sees whole frames.
// Ports:
//   clk, reset_n          core clock, synchronous active-low reset
//   frame_tick            one-cycle sample-rate strobe
//   rd_en/rd_addr         read request; rd_data/rd_valid one cycle later
//   wr_en/wr_addr/wr_data write request into the output stage
//   in_data/out_data      physical channels, channel 0 in the LSBs
//   addr_err, clip        sticky error flags, cleared by flag_clr
//   clip_count            saturating count of clamped writes
// Build option: define IO_CLIP_COUNT_EN to build the clip counter; otherwise clip_count is 0.
module dsp_io_bank #(
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned IO_WIDTH   = 24,
    parameter int unsigned NUM_IO     = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned GUARD_BITS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         frame_tick,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_IO*IO_WIDTH-1:0]   in_data,
    output logic [NUM_IO*IO_WIDTH-1:0]   out_data,
    output logic                         addr_err,
    output logic                         clip,
    input  logic                         flag_clr,
    output logic [15:0]                  clip_count
);

    import dsp_io_pkg::*;

    localparam int unsigned IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

    // The conversion helpers are sized by the package geometry.
    if (dsp_io_pkg::LSB_PAD < 0) begin : g_bad_pad
        $error("dsp_io_bank: DATA_WIDTH must be >= IO_WIDTH + GUARD_BITS");
    end
    if ((DATA_WIDTH != dsp_io_pkg::DATA_WIDTH) || (IO_WIDTH != dsp_io_pkg::IO_WIDTH) ||
        (GUARD_BITS != dsp_io_pkg::GUARD_BITS)) begin : g_bad_geom
        $error("dsp_io_bank: widths differ from dsp_io_pkg");
    end
    if ((NUM_IO < 1) || (NUM_IO > (2 ** ADDR_WIDTH))) begin : g_bad_num
        $error("dsp_io_bank: NUM_IO out of range for ADDR_WIDTH");
    end

    io_t in_shadow [NUM_IO];
    io_t out_stage [NUM_IO];

    logic             rd_in_range;
    logic             wr_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_hit;
    logic             clip_evt;
    logic             addr_evt;
    io_t              sat_value_c;
    logic             sat_clip_c;

    // Compare one bit wider so NUM_IO == 2**ADDR_WIDTH does not wrap to zero.
    assign rd_in_range = ({1'b0, rd_addr} < (ADDR_WIDTH+1)'(NUM_IO));
    assign wr_in_range = ({1'b0, wr_addr} < (ADDR_WIDTH+1)'(NUM_IO));
    assign rd_idx      = rd_addr[IDX_W-1:0];
    assign wr_idx      = wr_addr[IDX_W-1:0];

    assign wr_hit   = wr_en && wr_in_range;
    assign clip_evt = wr_hit && sat_clip_c;
    assign addr_evt = (rd_en && !rd_in_range) || (wr_en && !wr_in_range);

    dsp_io_sat u_sat (
        .w         (wr_data),
        .value_c   (sat_value_c),
        .clipped_c (sat_clip_c)
    );

    // Input snapshot; a same-edge read still sees the previous frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_IO; i++) begin
                in_shadow[i] <= '0;
            end
        end else if (frame_tick) begin
            for (int unsigned i = 0; i < NUM_IO; i++) begin
                in_shadow[i] <= in_data[i*IO_WIDTH +: IO_WIDTH];
            end
        end
    end

    // Read port: one-cycle latency, out-of-range reads return zero but still complete.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range ? sign_align(in_shadow[rd_idx]) : '0;
            end
        end
    end

    // Output stage; a write on a tick edge lands here and waits for the next tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_IO; i++) begin
                out_stage[i] <= '0;
            end
        end else if (wr_hit) begin
            out_stage[wr_idx] <= sat_value_c;
        end
    end

    // Commit the staged frame to the physical outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data <= '0;
        end else if (frame_tick) begin
            for (int unsigned i = 0; i < NUM_IO; i++) begin
                out_data[i*IO_WIDTH +: IO_WIDTH] <= out_stage[i];
            end
        end
    end

    // Sticky flags; a clear beats a same-cycle set.
    always_ff @(posedge clk) begin
        if (!reset_n || flag_clr) begin
            addr_err <= 1'b0;
            clip     <= 1'b0;
        end else begin
            if (addr_evt) addr_err <= 1'b1;
            if (clip_evt) clip     <= 1'b1;
        end
    end

`ifdef IO_CLIP_COUNT_EN
    logic [15:0] clip_cnt_q;

    // Saturating clamp counter; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!reset_n || flag_clr) begin
            clip_cnt_q <= '0;
        end else if (clip_evt && (clip_cnt_q != '1)) begin
            clip_cnt_q <= clip_cnt_q + 16'd1;
        end
    end

    assign clip_count = clip_cnt_q;
`else
    assign clip_count = '0;
`endif

endmodule

// File: tb/tb_dsp_io_bank.sv
// Directed self-checking bench for dsp_io_bank with hand-computed expectations.
module tb_dsp_io_bank;

    localparam int unsigned DW = 36;
    localparam int unsigned IW = 24;
    localparam int unsigned NIO = 8;
    localparam int unsigned AW = 10;

`ifdef IO_CLIP_COUNT_EN
    localparam logic [63:0] CNT_AFTER_ONE_CLIP = 64'd1;
`else
    localparam logic [63:0] CNT_AFTER_ONE_CLIP = 64'd0;
`endif

    logic              clk;
    logic              reset_n;
    logic              frame_tick;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NIO*IW-1:0] in_data;
    logic [NIO*IW-1:0] out_data;
    logic              addr_err;
    logic              clip;
    logic              flag_clr;
    logic [15:0]       clip_count;

    int checks;
    int failures;

    logic [IW-1:0] exp_out [NIO];

    dsp_io_bank dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .in_data    (in_data),
        .out_data   (out_data),
        .addr_err   (addr_err),
        .clip       (clip),
        .flag_clr   (flag_clr),
        .clip_count (clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic do_read(input int unsigned addr);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        step();
        rd_en   = 1'b0;
    endtask

    task automatic do_write(input int unsigned addr, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < int'(NIO); i++) begin
            check($sformatf("%s_ch%0d", tag, i), 64'(out_data[i*IW +: IW]), 64'(exp_out[i]));
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        flag_clr   = 1'b0;
        in_data    = '0;
        in_data[3*IW +: IW] = 24'h7FFFFF;
        for (int i = 0; i < int'(NIO); i++) exp_out[i] = '0;

        step();
        step();
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
        check("rst_clip", 64'(clip), 64'd0);
        check("rst_clip_count", 64'(clip_count), 64'd0);
        check_outputs("rst_out");

        reset_n = 1'b1;
        pulse_tick();

        // Snapshot read path
        do_read(3);
        check("rd3_valid", 64'(rd_valid), 64'd1);
        check("rd3_data", 64'(rd_data), 64'h0_7FFF_FF00);
        step();
        check("rd_idle_valid", 64'(rd_valid), 64'd0);
        check("rd_idle_hold", 64'(rd_data), 64'h0_7FFF_FF00);

        in_data[3*IW +: IW] = 24'h800000;
        do_read(3);
        check("rd3_no_tick", 64'(rd_data), 64'h0_7FFF_FF00);

        // Read issued on the tick edge still returns the old frame
        rd_en = 1'b1; rd_addr = AW'(3); frame_tick = 1'b1;
        step();
        rd_en = 1'b0; frame_tick = 1'b0;
        check("rd3_on_tick", 64'(rd_data), 64'h0_7FFF_FF00);
        do_read(3);
        check("rd3_after_tick", 64'(rd_data), 64'hF_8000_0000);

        // Back-to-back reads, one per cycle
        rd_en = 1'b1; rd_addr = AW'(3);
        step();
        check("b2b_first", 64'(rd_data), 64'hF_8000_0000);
        rd_addr = AW'(0);
        step();
        rd_en = 1'b0;
        check("b2b_second", 64'(rd_data), 64'd0);
        check("b2b_valid", 64'(rd_valid), 64'd1);

        // Write saturation
        do_write(1, 36'h0_8000_0000);
        check("clip_set", 64'(clip), 64'd1);
        do_write(2, 36'hF_8000_0000);
        check_outputs("pre_tick_out");
        pulse_tick();
        exp_out[1] = 24'h7FFFFF;
        exp_out[2] = 24'h800000;
        check_outputs("sat_out");
        check("clip_sticky", 64'(clip), 64'd1);
        check("clip_count_one", 64'(clip_count), CNT_AFTER_ONE_CLIP);
        check("addr_err_clean", 64'(addr_err), 64'd0);

        // Write colliding with a tick waits for the next tick
        wr_en = 1'b1; wr_addr = AW'(0); wr_data = 36'h0_0000_1100; frame_tick = 1'b1;
        step();
        wr_en = 1'b0; frame_tick = 1'b0;
        check_outputs("collide_same");
        pulse_tick();
        exp_out[0] = 24'h000011;
        check_outputs("collide_next");

        // Range checks
        do_read(8);
        check("oor_rd_data", 64'(rd_data), 64'd0);
        check("oor_rd_valid", 64'(rd_valid), 64'd1);
        check("oor_rd_err", 64'(addr_err), 64'd1);

        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("clr_addr_err", 64'(addr_err), 64'd0);
        check("clr_clip", 64'(clip), 64'd0);
        check("clr_clip_count", 64'(clip_count), 64'd0);

        do_write(1023, 36'h0_0000_1100);
        check("oor_wr_err", 64'(addr_err), 64'd1);
        pulse_tick();
        check_outputs("oor_wr_out");

        // Clear beats same-cycle sets
        flag_clr = 1'b1; rd_en = 1'b1; rd_addr = AW'(9);
        wr_en = 1'b1; wr_addr = AW'(4); wr_data = 36'h0_8000_0000;
        step();
        flag_clr = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        check("clr_vs_addr_err", 64'(addr_err), 64'd0);
        check("clr_vs_clip", 64'(clip), 64'd0);
        check("clr_vs_count", 64'(clip_count), 64'd0);

        // Reset mid-frame discards staged writes
        for (int i = 0; i < int'(NIO); i++) begin
            do_write(i, 36'h0_8000_0000);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        pulse_tick();
        for (int i = 0; i < int'(NIO); i++) exp_out[i] = '0;
        check_outputs("mid_rst_out");
        check("mid_rst_clip", 64'(clip), 64'd0);
        check("mid_rst_addr_err", 64'(addr_err), 64'd0);
        check("mid_rst_count", 64'(clip_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
